// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERROR   = 2'b10
    } hz_state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    // Per-stage hold/bubble enables driven to the stage registers.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
    } hz_ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one execute-stage operand; the memory stage wins over writeback.
module fwd_select
    import pipeline_pkg::*;
#(
    parameter int unsigned REGISTER_ADDRESS_WIDTH = 5
) (
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rsE,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3M,
    input  logic                              regWriteM,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3W,
    input  logic                              regWriteW,
    output logic [1:0]                        fwd
);

    logic hit_m;
    logic hit_w;

    // x0 is hard-wired to zero, so a match on it never forwards.
    always_comb begin
        hit_m = regWriteM && (AD3M == rsE) && (rsE != '0);
        hit_w = regWriteW && (AD3W == rsE) && (rsE != '0);
        if (hit_m) begin
            fwd = FWD_M;
        end else if (hit_w) begin
            fwd = FWD_W;
        end else begin
            fwd = FWD_NONE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipe, with memory-wait FSM and perf counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT            = 15,
    parameter int unsigned CNT_WIDTH              = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i,
    input  logic                              regWriteE_i,
    input  logic                              resultSrcE_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3M_i,
    input  logic                              regWriteM_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3W_i,
    input  logic                              regWriteW_i,
    input  logic                              branchTakenE_i,
    input  logic                              JALRE_i,
    input  logic                              memReqM_i,
    input  logic                              memReadyM_i,
    output logic                              stallF_o,
    output logic                              stallD_o,
    output logic                              stallE_o,
    output logic                              stallM_o,
    output logic                              flushD_o,
    output logic                              flushE_o,
    output logic [1:0]                        fwdAE_o,
    output logic [1:0]                        fwdBE_o,
    output logic                              busy_o,
    output logic                              timeout_o,
    output logic [CNT_WIDTH-1:0]              stallCnt_o,
    output logic [CNT_WIDTH-1:0]              flushCnt_o
);

    // waitCnt only ever holds 1..MEM_TIMEOUT-1; the step that would reach MEM_TIMEOUT traps.
    localparam int unsigned       WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t            state_q;
    logic [WAIT_W-1:0]    wait_cnt_q;
    logic                 timeout_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       hit1_d;
    logic       hit2_d;
    logic       lu;
    logic       ct;
    logic       mem_hold;
    hz_ctrl_t   ctrl;

    fwd_select #(
        .REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)
    ) u_fwd_a (
        .rsE      (rs1E_i),
        .AD3M     (AD3M_i),
        .regWriteM(regWriteM_i),
        .AD3W     (AD3W_i),
        .regWriteW(regWriteW_i),
        .fwd      (fwd_a)
    );

    fwd_select #(
        .REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)
    ) u_fwd_b (
        .rsE      (rs2E_i),
        .AD3M     (AD3M_i),
        .regWriteM(regWriteM_i),
        .AD3W     (AD3W_i),
        .regWriteW(regWriteW_i),
        .fwd      (fwd_b)
    );

    always_comb begin
        hit1_d = (AD3E_i == rs1D_i) && (rs1D_i != '0);
        hit2_d = (AD3E_i == rs2D_i) && (rs2D_i != '0);
        lu     = resultSrcE_i && regWriteE_i && (hit1_d || hit2_d);
        ct     = branchTakenE_i || JALRE_i;

        // A ready response in MEMWAIT releases the pipe in the same cycle, so a branch
        // held in E is allowed to flush on that release cycle.
        unique case (state_q)
            RUN:     mem_hold = memReqM_i && !memReadyM_i;
            MEMWAIT: mem_hold = !memReadyM_i;
            default: mem_hold = 1'b1;
        endcase

        ctrl = '0;
        if (rst) begin
            ctrl = '0;
        end else if (mem_hold) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
        end else if (ct) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (lu) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end
    end

    assign stallF_o   = ctrl.stall_f;
    assign stallD_o   = ctrl.stall_d;
    assign stallE_o   = ctrl.stall_e;
    assign stallM_o   = ctrl.stall_m;
    assign flushD_o   = ctrl.flush_d;
    assign flushE_o   = ctrl.flush_e;
    assign fwdAE_o    = rst ? FWD_NONE : fwd_a;
    assign fwdBE_o    = rst ? FWD_NONE : fwd_b;
    assign busy_o     = (state_q == MEMWAIT);
    assign timeout_o  = timeout_q;
    assign stallCnt_o = stall_cnt_q;
    assign flushCnt_o = flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (memReqM_i && !memReadyM_i) begin
                        state_q    <= MEMWAIT;
                        wait_cnt_q <= WAIT_ONE;
                    end
                end
                MEMWAIT: begin
                    if (memReadyM_i) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q >= WAIT_LAST) begin
                        state_q   <= ERROR;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_ONE;
                    end
                end
                default: begin
                    timeout_q <= 1'b1;
                end
            endcase
        end
    end

    // Only control hazards assert flushD, so it marks exactly the flushes taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctrl.stall_f && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (ctrl.flush_d && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: a default instance and a small instance (MEM_TIMEOUT=4, CNT_WIDTH=2).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RAW = 5;

    typedef struct packed {
        logic       sf;
        logic       sd;
        logic       se;
        logic       sm;
        logic       fd;
        logic       fe;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       busy;
        logic       tmo;
    } ctl_t;

    // mode: 0 running, 1 waiting on memory, 2 timed out
    typedef struct {
        int mode;
        int waited;
        int scnt;
        int fcnt;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [RAW-1:0] rs1D, rs2D, rs1E, rs2E, AD3E, AD3M, AD3W;
    logic regWriteE, resultSrcE, regWriteM, regWriteW, branchTakenE, JALRE, memReqM, memReadyM;

    ctl_t        ob, os;
    logic [15:0] b_scnt, b_fcnt;
    logic [1:0]  s_scnt, s_fcnt;

    mdl_t mb, ms;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_big (
        .clk(clk), .rst(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E), .AD3E_i(AD3E),
        .regWriteE_i(regWriteE), .resultSrcE_i(resultSrcE),
        .AD3M_i(AD3M), .regWriteM_i(regWriteM), .AD3W_i(AD3W), .regWriteW_i(regWriteW),
        .branchTakenE_i(branchTakenE), .JALRE_i(JALRE),
        .memReqM_i(memReqM), .memReadyM_i(memReadyM),
        .stallF_o(ob.sf), .stallD_o(ob.sd), .stallE_o(ob.se), .stallM_o(ob.sm),
        .flushD_o(ob.fd), .flushE_o(ob.fe), .fwdAE_o(ob.fa), .fwdBE_o(ob.fb),
        .busy_o(ob.busy), .timeout_o(ob.tmo), .stallCnt_o(b_scnt), .flushCnt_o(b_fcnt)
    );

    pipeline_hazard_ctrl #(
        .REGISTER_ADDRESS_WIDTH(RAW), .MEM_TIMEOUT(4), .CNT_WIDTH(2)
    ) u_small (
        .clk(clk), .rst(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E), .AD3E_i(AD3E),
        .regWriteE_i(regWriteE), .resultSrcE_i(resultSrcE),
        .AD3M_i(AD3M), .regWriteM_i(regWriteM), .AD3W_i(AD3W), .regWriteW_i(regWriteW),
        .branchTakenE_i(branchTakenE), .JALRE_i(JALRE),
        .memReqM_i(memReqM), .memReadyM_i(memReadyM),
        .stallF_o(os.sf), .stallD_o(os.sd), .stallE_o(os.se), .stallM_o(os.sm),
        .flushD_o(os.fd), .flushE_o(os.fe), .fwdAE_o(os.fa), .fwdBE_o(os.fb),
        .busy_o(os.busy), .timeout_o(os.tmo), .stallCnt_o(s_scnt), .flushCnt_o(s_fcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic same_reg(input logic [RAW-1:0] a, input logic [RAW-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [RAW-1:0] rs);
        if (regWriteM && same_reg(AD3M, rs)) return 2'b10;
        if (regWriteW && same_reg(AD3W, rs)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic ctl_t exp_ctl(input mdl_t m);
        ctl_t c;
        logic hold, lu, ct;
        c = '0;
        if (rst) return c;
        lu = resultSrcE && regWriteE && (same_reg(AD3E, rs1D) || same_reg(AD3E, rs2D));
        ct = branchTakenE || JALRE;
        hold = (m.mode == 2) || (m.mode == 1 && !memReadyM) || (m.mode == 0 && memReqM && !memReadyM);
        if (hold) {c.sf, c.sd, c.se, c.sm} = 4'b1111;
        else if (ct) {c.fd, c.fe} = 2'b11;
        else if (lu) {c.sf, c.sd, c.fe} = 3'b111;
        c.fa   = exp_fwd(rs1E);
        c.fb   = exp_fwd(rs2E);
        c.busy = (m.mode == 1);
        c.tmo  = (m.mode == 2);
        return c;
    endfunction

    function automatic mdl_t step(input mdl_t m, input ctl_t c, input int limit, input int cmax);
        mdl_t n = m;
        if (c.sf) n.scnt = (m.scnt + 1 > cmax) ? cmax : m.scnt + 1;
        if (c.fd) n.fcnt = (m.fcnt + 1 > cmax) ? cmax : m.fcnt + 1;
        if (m.mode == 0 && memReqM && !memReadyM) begin
            n.mode   = 1;
            n.waited = 1;
        end else if (m.mode == 1) begin
            if (memReadyM) begin
                n.mode = 0;
            end else begin
                n.waited = m.waited + 1;
                if (n.waited >= limit) n.mode = 2;
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        ctl_t eb, es;
        eb = exp_ctl(mb);
        es = exp_ctl(ms);
        check("cyc_ctl_big", 32'(ob), 32'(eb));
        check("cyc_ctl_small", 32'(os), 32'(es));
        check("cyc_cnt_big", {b_scnt, b_fcnt}, rst ? 32'd0 : {mb.scnt[15:0], mb.fcnt[15:0]});
        check("cyc_cnt_small", 32'({s_scnt, s_fcnt}),
              rst ? 32'd0 : 32'({ms.scnt[1:0], ms.fcnt[1:0]}));
        if (rst) begin
            mb = '{default: 0};
            ms = '{default: 0};
        end else begin
            mb = step(mb, eb, 15, 65535);
            ms = step(ms, es, 4, 3);
        end
    end

    task automatic idle();
        {rs1D, rs2D, rs1E, rs2E, AD3E, AD3M, AD3W} = '0;
        {regWriteE, resultSrcE, regWriteM, regWriteW} = '0;
        {branchTakenE, JALRE, memReqM, memReadyM} = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1 rst = 1'b1;
        #2;
        check("reset_outputs", 32'(ob), 32'd0);
        #9 rst = 1'b0;
        #1;
        check("reset_counters", {b_scnt, b_fcnt}, 32'd0);

        cyc(); rs1E = 5; rs2E = 5; AD3M = 5; regWriteM = 1; AD3W = 5; regWriteW = 1; #1;
        check("fwd_m_priority", 32'(ob.fa), 32'd2);
        check("fwd_b_m", 32'(ob.fb), 32'd2);
        cyc(); regWriteM = 0; #1;
        check("fwd_w", 32'(ob.fa), 32'd1);
        cyc(); rs1E = 0; AD3M = 0; AD3W = 0; regWriteM = 1; #1;
        check("fwd_x0", 32'(ob.fa), 32'd0);

        cyc(); idle(); resultSrcE = 1; regWriteE = 1; AD3E = 7; rs2D = 7; #1;
        check("load_use", 32'({ob.sf, ob.sd, ob.se, ob.sm, ob.fd, ob.fe}), 32'b110001);
        cyc(); idle(); #1;
        check("load_use_one_cycle", 32'({ob.sf, ob.sd, ob.se, ob.sm, ob.fd, ob.fe}), 32'd0);
        cyc(); resultSrcE = 1; regWriteE = 1; AD3E = 7; rs2D = 7; branchTakenE = 1; #1;
        check("ct_over_lu", 32'({ob.sf, ob.sd, ob.se, ob.sm, ob.fd, ob.fe}), 32'b000011);
        cyc(); idle(); resultSrcE = 1; regWriteE = 1; #1;
        check("lu_x0", 32'({ob.sf, ob.sd, ob.fe}), 32'd0);
        check("flush_cnt_one", 32'(b_fcnt), 32'd1);
        check("stall_cnt_one", 32'(b_scnt), 32'd1);

        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); memReqM = 1; #1;
            check("memwait_stalls", 32'({ob.sf, ob.sd, ob.se, ob.sm, ob.fd, ob.fe}), 32'b111100);
            check("memwait_busy", 32'(ob.busy), (i == 0) ? 32'd0 : 32'd1);
            if (i == 3) check("timeout_not_early", 32'(os.tmo), 32'd0);
        end
        cyc(); memReadyM = 1; #1;
        check("memwait_release", 32'({ob.sf, ob.sd, ob.se, ob.sm}), 32'd0);
        check("timeout_set", 32'(os.tmo), 32'd1);
        check("timeout_stalls_held", 32'({os.sf, os.sd, os.se, os.sm}), 32'b1111);
        cyc(); idle(); memReadyM = 1; #1;
        check("memwait_stall_cnt", 32'(b_scnt), 32'd5);
        check("memwait_back_run", 32'(ob.busy), 32'd0);
        check("timeout_sticky", 32'(os.tmo), 32'd1);

        cyc(); idle(); memReqM = 1;
        cyc(); #1;
        check("pre_rst_busy", 32'(ob.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_ctl", 32'(ob), 32'd0);
        check("rst_async_cnt", {b_scnt, b_fcnt}, 32'd0);
        check("rst_clears_timeout", 32'(os.tmo), 32'd0);
        #3 rst = 1'b0;
        idle();

        for (int i = 0; i < 5; i++) begin
            cyc(); idle(); if (i % 2 == 0) branchTakenE = 1; else JALRE = 1; #1;
            check("ct_flush", 32'({ob.fd, ob.fe, ob.sf}), 32'b110);
        end
        cyc(); idle(); #1;
        check("flush_cnt_saturated", 32'(s_fcnt), 32'd3);
        check("flush_cnt_five", 32'(b_fcnt), 32'd5);

        cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
